f8_mem_arbiter: RTL

- Shares one single-port synchronous data RAM between the f8 core (port C) and a DMA/debug master (port D).
- Sits inside system between the core's data bus and the RAM macro.
- Priority is fixed to the core, with a starvation guard for D.
- Flags out-of-range accesses on a sticky trap output that feeds the system trap line.

---
 rtl/f8_mem_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/f8_mem_arbiter.sv
// f8_mem_arbiter: shares one single-port data RAM between the f8 core (C) and a DMA/debug master (D)
module f8_mem_arbiter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 16'h2000,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 16'h0800,
    parameter int                    MAX_WAIT   = 3
) (
    input  logic                          clk,
    input  logic                          power_on_reset_n,
    input  logic                          c_req,
    input  logic                          c_we,
    input  logic [ADDR_WIDTH-1:0]         c_addr,
    input  logic [DATA_WIDTH-1:0]         c_wdata,
    output logic                          c_gnt,
    output logic                          c_rvalid,
    output logic [DATA_WIDTH-1:0]         c_rdata,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_WIDTH-1:0]         d_addr,
    input  logic [DATA_WIDTH-1:0]         d_wdata,
    output logic                          d_gnt,
    output logic                          d_rvalid,
    output logic [DATA_WIDTH-1:0]         d_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [$clog2(MEM_SIZE)-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          trap
);
    localparam int MW = $clog2(MEM_SIZE);
    localparam logic [3:0] MAXW = 4'(MAX_WAIT);
    localparam logic [ADDR_WIDTH:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    typedef enum logic [1:0] {SEL_NONE, SEL_C, SEL_D} sel_t;

    sel_t                  rsel;
    logic [3:0]            wait_cnt;
    logic                  r_oor;
    logic [DATA_WIDTH-1:0] c_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         addr_q;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  g_we;
    logic                  any_gnt;
    logic                  in_range;
    logic                  acc_ok;

    assign d_gnt    = power_on_reset_n && d_req && (!c_req || wait_cnt == MAXW);
    assign c_gnt    = power_on_reset_n && c_req && !d_gnt;
    assign any_gnt  = c_gnt || d_gnt;
    assign g_addr   = d_gnt ? d_addr : c_addr;
    assign g_we     = d_gnt ? d_we : c_we;
    assign g_wdata  = d_gnt ? d_wdata : c_wdata;
    assign in_range = (g_addr >= MEM_BASE) && ({1'b0, g_addr} < MEM_END);
    assign acc_ok   = any_gnt && in_range;

    assign mem_en    = acc_ok;
    assign mem_we    = acc_ok && g_we;
    assign mem_addr  = acc_ok ? MW'(g_addr - MEM_BASE) : addr_q;
    assign mem_wdata = acc_ok ? g_wdata : wdata_q;

    assign c_rvalid = rsel == SEL_C;
    assign d_rvalid = rsel == SEL_D;
    assign c_rdata  = c_rvalid ? (r_oor ? '0 : mem_rdata) : c_rdata_q;
    assign d_rdata  = d_rvalid ? (r_oor ? '0 : mem_rdata) : d_rdata_q;

    // Arbitration history, read-return owner, held read data and the sticky trap
    always_ff @(posedge clk) begin
        if (!power_on_reset_n) begin
            wait_cnt  <= '0;
            rsel      <= SEL_NONE;
            r_oor     <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            trap      <= 1'b0;
        end else begin
            wait_cnt  <= d_gnt ? 4'd0 : (d_req && wait_cnt != MAXW) ? wait_cnt + 4'd1 : wait_cnt;
            rsel      <= (any_gnt && !g_we) ? (d_gnt ? SEL_D : SEL_C) : SEL_NONE;
            r_oor     <= !in_range;
            c_rdata_q <= c_rdata;
            d_rdata_q <= d_rdata;
            trap      <= trap || (any_gnt && !in_range);
        end
    end

    // RAM address and write data hold their last driven value while no access is issued
    always_ff @(posedge clk) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
    end
endmodule
